sram_1r1w_wrapper: RTL and testbench
====================================

Name: sram_1r1w_wrapper

Overview:
- Parametrised single-clock 1-read/1-write SRAM macro model for behavioural simulation and FPGA builds of cache/predictor arrays.
- Generalises the fixed 16x128 two-port macro model in width, depth and mask granularity.
- Adds byte-masked writes, read-during-write bypass, a selectable output register, deterministic read-hold, and a post-reset zero-initialisation sweep with ready handshake.

Parameters:
- DATA_WIDTH, 128, bits per entry.
- DEPTH, 16, number of entries; need not be a power of 2.
- ADDR_WIDTH, 4, address bits; must satisfy 2^ADDR_WIDTH >= DEPTH.
- MASK_UNIT, 8, bits per write-mask lane; DATA_WIDTH must be a multiple of it. MASK_WIDTH = DATA_WIDTH/MASK_UNIT.
- BYPASS, 1, 1 = same-address read-during-write returns new data; 0 = returns old data.
- HOLD_READ, 1, 1 = r_data holds last read value when no read; 0 = r_data is driven to 0 when no read.
- OUT_REG, 0, 1 = extra output register stage (read latency 2).
- INIT_ON_RESET, 1, 1 = zero every entry after reset before accepting requests.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- ready  out  1  array accepts reads/writes; low during the init sweep.
- w_en  in  1  write request.
- w_addr  in  ADDR_WIDTH  write address.
- w_data  in  DATA_WIDTH  write data.
- w_mask  in  MASK_WIDTH  lane enables; bit i covers data bits [i*MASK_UNIT +: MASK_UNIT].
- r_en  in  1  read request.
- r_addr  in  ADDR_WIDTH  read address.
- r_data  out  DATA_WIDTH  read data.
- r_valid  out  1  one-cycle pulse, aligned with new r_data.

Behaviour:
- **Reset** (sampled at an edge with reset=1):
  - r_data=0, r_valid=0, OUT_REG pipeline cleared, init counter=0.
  - Next state is INIT if INIT_ON_RESET=1, else READY.
  - ready=0 while reset is asserted.
  - Array contents are not cleared by reset itself.
- **FSM INIT:**
  - Each cycle, write all-zero to entry cnt, then cnt++.
  - On the edge that writes entry DEPTH-1, go to READY; ready=1 from the following cycle.
  - INIT takes exactly DEPTH cycles after reset deasserts.
  - w_en/r_en are ignored in INIT: no array change, no r_valid.
  - Reset asserted mid-INIT restarts the sweep at cnt=0.
- **FSM READY:**
  - Terminal state; left only by reset.
  - ready=1.
- **Write** (w_en & ready at edge):
  - For each lane with w_mask[i]=1, that lane of entry w_addr takes w_data.
  - Lanes with mask 0 are unchanged.
  - w_mask=0 is a legal no-op.
- **Read** (r_en & ready at edge T):
  - OUT_REG=0: r_data updated and r_valid=1 in the cycle after edge T.
  - OUT_REG=1: the same, one cycle later.
  - Back-to-back reads are fully pipelined, one per cycle.
  - r_valid is 0 in any cycle without a corresponding accepted read.
- **Same edge, same address, both enabled:**
  - BYPASS=1: r_data = merge(old, w_data, w_mask); new data in masked lanes, old elsewhere.
  - BYPASS=0: r_data = old entry.
  - Different addresses: independent.
- **No accepted read:**
  - HOLD_READ=1: r_data holds its previous value.
  - HOLD_READ=0: r_data=0.
  - Never X/random.
- **Out-of-range address** (addr >= DEPTH):
  - Write is ignored.
  - Read returns all-zero with r_valid=1.
- No X propagation from unwritten entries when INIT_ON_RESET=1.

Test Plan:
1. **Init sweep.** Defaults, reset for 2 cycles, then deassert; hold w_en=1, r_en=1 throughout.
   - ready=0 for exactly 16 cycles, then 1.
   - No r_valid during INIT.
   - Reading all 16 entries afterwards returns 0.
2. **Masked write.** Write addr 3 = all-0xFF with w_mask=all ones, then write addr 3 = 0x00..00 with w_mask=16'h0001, then read addr 3.
   - r_data = 0xFF..FF00, r_valid=1 one cycle after the read edge.
3. **Read-during-write.** Entry 5 = 0xAAAA..AA. Same edge: write addr 5 data 0x5555..55 mask 16'h00FF, and read addr 5.
   - BYPASS=1: r_data = upper 8 bytes 0xAA, lower 8 bytes 0x55.
   - BYPASS=0: r_data = 0xAA..AA.
4. **Hold and pipeline.** OUT_REG=1, HOLD_READ=1. Read addr 1 (holding 0x1) then addr 2 (holding 0x2) on consecutive edges, then idle 3 cycles.
   - r_valid high at T+2 and T+3 with data 0x1 then 0x2.
   - r_data stays 0x2 with r_valid=0 afterwards.
   - With HOLD_READ=0, r_data=0 after the second valid.
5. **Reset mid-INIT.** Assert reset at INIT cycle 7, deassert.
   - ready rises exactly 16 cycles after the deassert.
   - Any pre-reset write, from a prior READY period, to addr 12 reads back 0.
6. **Non-power-of-2 depth.** DEPTH=12, ADDR_WIDTH=4. Write addr 13 = 0x1234, read addr 13, read addr 11.
   - Addr 13 read returns 0 with r_valid=1.
   - Addr 11 returns 0 (initialised); no entry is altered.

Source files
------------

// File: rtl/sram_1r1w_wrapper.sv
// sram_1r1w_wrapper: parametrised 1-read/1-write SRAM model with lane-masked writes,
// read-during-write bypass, optional output register and post-reset zero-init sweep.
module sram_1r1w_wrapper #(
    parameter int DATA_WIDTH    = 128,
    parameter int DEPTH         = 16,
    parameter int ADDR_WIDTH    = 4,
    parameter int MASK_UNIT     = 8,
    parameter bit BYPASS        = 1'b1,
    parameter bit HOLD_READ     = 1'b1,
    parameter bit OUT_REG       = 1'b0,
    parameter bit INIT_ON_RESET = 1'b1,
    localparam int MASK_WIDTH   = DATA_WIDTH / MASK_UNIT
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  ready,
    input  logic                  w_en,
    input  logic [ADDR_WIDTH-1:0] w_addr,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic [MASK_WIDTH-1:0] w_mask,
    input  logic                  r_en,
    input  logic [ADDR_WIDTH-1:0] r_addr,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic                  r_valid
);
    typedef enum logic {INIT, READY} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_A = (ADDR_WIDTH + 1)'(DEPTH);

    // Sized to the full address space so any address indexes legally; entries >= DEPTH are never touched.
    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] cnt_q;
    logic                  ready_q;
    logic [DATA_WIDTH-1:0] bit_mask, old_word, rd_word_d, src_data, r_data_d, p_data_q, r_data_q;
    logic                  wr_ok, rd_ok, src_valid, p_valid_q, r_valid_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= INIT_ON_RESET ? INIT : READY;
            cnt_q   <= '0;
            ready_q <= !INIT_ON_RESET;
        end else if (state_q == INIT) begin
            cnt_q <= cnt_q + ADDR_WIDTH'(1);
            if (cnt_q == LAST) begin
                state_q <= READY;
                ready_q <= 1'b1;
            end
        end
    end

    assign ready = ready_q && !reset;
    assign wr_ok = w_en && ready && ({1'b0, w_addr} < DEPTH_A);
    assign rd_ok = r_en && ready;

    always_comb begin
        bit_mask = '0;
        for (int i = 0; i < MASK_WIDTH; i++)
            bit_mask[i*MASK_UNIT +: MASK_UNIT] = {MASK_UNIT{w_mask[i]}};
    end

    always_ff @(posedge clock) begin
        if (state_q == INIT && !reset)
            mem_q[cnt_q] <= '0;
        else if (wr_ok)
            mem_q[w_addr] <= (mem_q[w_addr] & ~bit_mask) | (w_data & bit_mask);
    end

    assign old_word  = ({1'b0, r_addr} < DEPTH_A) ? mem_q[r_addr] : '0;
    assign rd_word_d = (BYPASS && wr_ok && w_addr == r_addr) ?
                       (old_word & ~bit_mask) | (w_data & bit_mask) : old_word;

    // With OUT_REG the p_* stage adds the extra cycle; otherwise it is bypassed.
    assign src_valid = OUT_REG ? p_valid_q : rd_ok;
    assign src_data  = OUT_REG ? p_data_q : rd_word_d;
    assign r_data_d  = src_valid ? src_data : HOLD_READ ? r_data_q : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            p_valid_q <= 1'b0;
            p_data_q  <= '0;
            r_valid_q <= 1'b0;
            r_data_q  <= '0;
        end else begin
            p_valid_q <= rd_ok;
            if (rd_ok) p_data_q <= rd_word_d;
            r_valid_q <= src_valid;
            r_data_q  <= r_data_d;
        end
    end

    assign r_data  = r_data_q;
    assign r_valid = r_valid_q;
endmodule

// File: tb/tb_sram_1r1w_wrapper.sv
// tb_sram_1r1w_wrapper: directed bench driving three differently-configured
// instances (default; DEPTH=12/no-bypass/out-reg; no-hold/out-reg) from shared inputs.
module tb_sram_1r1w_wrapper;
    localparam int DW = 128;
    localparam int MW = 16;
    localparam int AW = 4;
    localparam logic [DW-1:0] Z = '0;

    logic          clock = 1'b0, reset = 1'b1, w_en = 1'b0, r_en = 1'b0;
    logic [AW-1:0] w_addr = '0, r_addr = '0;
    logic [DW-1:0] w_data = '0;
    logic [MW-1:0] w_mask = '0;
    logic          rdy0, rdy1, rdy2, rv0, rv1, rv2;
    logic [DW-1:0] rd0, rd1, rd2;
    int passed = 0, total = 0;

    always #5 clock = ~clock;

    sram_1r1w_wrapper d0 (
        .clock(clock), .reset(reset), .ready(rdy0), .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
        .w_mask(w_mask), .r_en(r_en), .r_addr(r_addr), .r_data(rd0), .r_valid(rv0));
    sram_1r1w_wrapper #(.DEPTH(12), .BYPASS(1'b0), .OUT_REG(1'b1)) d1 (
        .clock(clock), .reset(reset), .ready(rdy1), .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
        .w_mask(w_mask), .r_en(r_en), .r_addr(r_addr), .r_data(rd1), .r_valid(rv1));
    sram_1r1w_wrapper #(.HOLD_READ(1'b0), .OUT_REG(1'b1)) d2 (
        .clock(clock), .reset(reset), .ready(rdy2), .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
        .w_mask(w_mask), .r_en(r_en), .r_addr(r_addr), .r_data(rd2), .r_valid(rv2));

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; w_en = 1'b1; r_en = 1'b1; w_addr = 4'd15; r_addr = 4'd15;
        w_data = '1; w_mask = '1;
        tick; tick;
        total++;
        if ({rdy0, rdy1, rdy2} !== 3'b000) $display("FAIL reset_ready got=%b exp=000", {rdy0, rdy1, rdy2});
        else passed++;
        total++;
        if ({rv0, rv1, rv2} !== 3'b000) $display("FAIL reset_valid got=%b exp=000", {rv0, rv1, rv2});
        else passed++;
        total++;
        if ({rd0, rd1, rd2} !== {3*DW{1'b0}}) $display("FAIL reset_data got=%h %h %h exp=0", rd0, rd1, rd2);
        else passed++;
    endtask

    task automatic test_init_sweep;
        int n, n1;
        reset = 1'b0; n = 0; n1 = -1;
        while (!rdy0 && n < 40) begin
            total++;
            if (rv0 || rv2) $display("FAIL init_valid cycle=%0d got rv0=%b rv2=%b exp=0", n, rv0, rv2);
            else passed++;
            if (rdy1 && n1 < 0) n1 = n;
            n++;
            tick;
        end
        w_en = 1'b0; r_en = 1'b0;
        total++;
        if (n != 16) $display("FAIL init_len got=%0d exp=16", n);
        else passed++;
        total++;
        if (n1 != 12) $display("FAIL init_len_d12 got=%0d exp=12", n1);
        else passed++;
        r_en = 1'b1;
        for (int a = 0; a < 16; a++) begin
            r_addr = AW'(a);
            tick;
            total++;
            if ({rv0, rd0} !== {1'b1, Z}) $display("FAIL init_zero a=%0d got rv=%b d=%h exp rv=1 d=0", a, rv0, rd0);
            else passed++;
            if (a > 0) begin
                total++;
                if ({rv1, rd1, rv2, rd2} !== {1'b1, Z, 1'b1, Z})
                    $display("FAIL init_zero_reg a=%0d got rv1=%b d1=%h rv2=%b d2=%h exp rv=1 d=0", a, rv1, rd1, rv2, rd2);
                else passed++;
            end
        end
        r_en = 1'b0;
        tick; tick;
    endtask

    task automatic test_masked_write;
        logic [DW-1:0] exp;
        exp = {{15{8'hFF}}, 8'h00};
        w_en = 1'b1; w_addr = 4'd3; w_data = '1; w_mask = '1;
        tick;
        w_data = '0; w_mask = 16'h0001;
        tick;
        w_mask = '0;
        tick;
        w_en = 1'b0; r_en = 1'b1; r_addr = 4'd3;
        tick;
        r_en = 1'b0;
        total++;
        if ({rv0, rd0} !== {1'b1, exp}) $display("FAIL mask_d0 got rv=%b d=%h exp rv=1 d=%h", rv0, rd0, exp);
        else passed++;
        tick;
        total++;
        if ({rv0, rd0} !== {1'b0, exp}) $display("FAIL mask_hold got rv=%b d=%h exp rv=0 d=%h", rv0, rd0, exp);
        else passed++;
        total++;
        if ({rv1, rd1, rv2, rd2} !== {1'b1, exp, 1'b1, exp})
            $display("FAIL mask_outreg got rv1=%b d1=%h rv2=%b d2=%h exp rv=1 d=%h", rv1, rd1, rv2, rd2, exp);
        else passed++;
        tick;
        total++;
        if ({rv2, rd2} !== {1'b0, Z}) $display("FAIL mask_nohold got rv=%b d=%h exp rv=0 d=0", rv2, rd2);
        else passed++;
    endtask

    task automatic test_read_during_write;
        logic [DW-1:0] mrg, old;
        old = {16{8'hAA}};
        mrg = {{8{8'hAA}}, {8{8'h55}}};
        w_en = 1'b1; w_addr = 4'd5; w_data = old; w_mask = '1;
        tick;
        w_data = {16{8'h55}}; w_mask = 16'h00FF; r_en = 1'b1; r_addr = 4'd5;
        tick;
        w_en = 1'b0; r_en = 1'b0;
        total++;
        if ({rv0, rd0} !== {1'b1, mrg}) $display("FAIL rdw_bypass got rv=%b d=%h exp rv=1 d=%h", rv0, rd0, mrg);
        else passed++;
        tick;
        total++;
        if ({rv1, rd1} !== {1'b1, old}) $display("FAIL rdw_nobypass got rv=%b d=%h exp rv=1 d=%h", rv1, rd1, old);
        else passed++;
        total++;
        if ({rv2, rd2} !== {1'b1, mrg}) $display("FAIL rdw_bypass_reg got rv=%b d=%h exp rv=1 d=%h", rv2, rd2, mrg);
        else passed++;
        r_en = 1'b1;
        tick;
        r_en = 1'b0;
        total++;
        if ({rv0, rd0} !== {1'b1, mrg}) $display("FAIL rdw_array got rv=%b d=%h exp rv=1 d=%h", rv0, rd0, mrg);
        else passed++;
        tick;
        total++;
        if ({rv1, rd1} !== {1'b1, mrg}) $display("FAIL rdw_array_d1 got rv=%b d=%h exp rv=1 d=%h", rv1, rd1, mrg);
        else passed++;
        tick;
    endtask

    task automatic test_back_to_back;
        logic [DW-1:0] one, two;
        one = DW'(1); two = DW'(2);
        w_en = 1'b1; w_mask = '1; w_addr = 4'd1; w_data = one;
        tick;
        w_addr = 4'd2; w_data = two;
        tick;
        w_en = 1'b0; r_en = 1'b1; r_addr = 4'd1;
        tick;
        r_addr = 4'd2;
        tick;
        r_en = 1'b0;
        total++;
        if ({rv0, rd0, rv1, rd1, rv2, rd2} !== {1'b1, two, 1'b1, one, 1'b1, one})
            $display("FAIL b2b_first got rv0=%b d0=%h rv1=%b d1=%h rv2=%b d2=%h exp 1/2 1/1 1/1", rv0, rd0, rv1, rd1, rv2, rd2);
        else passed++;
        tick;
        total++;
        if ({rv0, rd0, rv1, rd1, rv2, rd2} !== {1'b0, two, 1'b1, two, 1'b1, two})
            $display("FAIL b2b_second got rv0=%b d0=%h rv1=%b d1=%h rv2=%b d2=%h exp 0/2 1/2 1/2", rv0, rd0, rv1, rd1, rv2, rd2);
        else passed++;
        for (int k = 0; k < 3; k++) begin
            tick;
            total++;
            if ({rv1, rd1, rv2, rd2} !== {1'b0, two, 1'b0, Z})
                $display("FAIL b2b_idle k=%0d got rv1=%b d1=%h rv2=%b d2=%h exp 0/2 0/0", k, rv1, rd1, rv2, rd2);
            else passed++;
        end
    endtask

    task automatic test_reset_mid_init;
        logic [DW-1:0] pat;
        int n;
        pat = DW'(32'hDEAD_BEEF);
        w_en = 1'b1; w_addr = 4'd12; w_data = pat; w_mask = '1;
        tick;
        w_en = 1'b0; r_en = 1'b1; r_addr = 4'd12;
        tick;
        r_en = 1'b0;
        total++;
        if ({rv0, rd0} !== {1'b1, pat}) $display("FAIL mid_prewrite got rv=%b d=%h exp rv=1 d=%h", rv0, rd0, pat);
        else passed++;
        reset = 1'b1;
        #1;
        total++;
        if ({rdy0, rdy2} !== 2'b00) $display("FAIL mid_ready_in_reset got=%b exp=00", {rdy0, rdy2});
        else passed++;
        tick;
        reset = 1'b0;
        repeat (7) tick;
        total++;
        if (rdy0 !== 1'b0) $display("FAIL mid_ready_init got=%b exp=0", rdy0);
        else passed++;
        reset = 1'b1;
        tick;
        reset = 1'b0; n = 0;
        while (!rdy0 && n < 40) begin
            n++;
            tick;
        end
        total++;
        if (n != 16) $display("FAIL mid_init_len got=%0d exp=16", n);
        else passed++;
        r_en = 1'b1; r_addr = 4'd12;
        tick;
        r_en = 1'b0;
        total++;
        if ({rv0, rd0} !== {1'b1, Z}) $display("FAIL mid_cleared got rv=%b d=%h exp rv=1 d=0", rv0, rd0);
        else passed++;
        tick;
        total++;
        if ({rv1, rd1, rv2, rd2} !== {1'b1, Z, 1'b1, Z})
            $display("FAIL mid_cleared_reg got rv1=%b d1=%h rv2=%b d2=%h exp rv=1 d=0", rv1, rd1, rv2, rd2);
        else passed++;
    endtask

    task automatic test_out_of_range;
        logic [DW-1:0] pat;
        pat = DW'(16'h1234);
        w_en = 1'b1; w_addr = 4'd13; w_data = pat; w_mask = '1;
        tick;
        w_en = 1'b0; r_en = 1'b1; r_addr = 4'd13;
        tick;
        total++;
        if ({rv0, rd0} !== {1'b1, pat}) $display("FAIL oor_d0_inrange got rv=%b d=%h exp rv=1 d=%h", rv0, rd0, pat);
        else passed++;
        r_addr = 4'd11;
        tick;
        r_en = 1'b0;
        total++;
        if ({rv1, rd1} !== {1'b1, Z}) $display("FAIL oor_read13 got rv=%b d=%h exp rv=1 d=0", rv1, rd1);
        else passed++;
        tick;
        total++;
        if ({rv1, rd1} !== {1'b1, Z}) $display("FAIL oor_read11 got rv=%b d=%h exp rv=1 d=0", rv1, rd1);
        else passed++;
        tick;
        total++;
        if (rv1 !== 1'b0) $display("FAIL oor_valid_drop got=%b exp=0", rv1);
        else passed++;
    endtask

    initial begin
        test_reset;
        test_init_sweep;
        test_masked_write;
        test_read_during_write;
        test_back_to_back;
        test_reset_mid_init;
        test_out_of_range;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
